// File: rtl/ex_103_pkg.sv
// Shared types and constants for the vector sequencer and the AND test-vector block.
package ex_103_pkg;

    localparam int DEFAULT_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ex_103_vector_ram.sv
// Operand-pair table: one synchronous write port and one synchronous read port.
// Reset only clears the read register; the stored table survives reset.
module ex_103_vector_ram #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [2*WIDTH-1:0] wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [2*WIDTH-1:0] rd_data
);

    logic [2*WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read and write share an edge, so a same-address access returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ex_103_vector_sequencer.sv
// Plays a writable table of (a, b) operand pairs, each held HOLD_CYCLES clocks,
// with start/stop control, optional looping and a completion pulse.
module ex_103_vector_sequencer
    import ex_103_pkg::*;
#(
    parameter  int WIDTH       = DEFAULT_WIDTH,
    parameter  int DEPTH       = 8,
    parameter  int HOLD_CYCLES = 50,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_a,
    input  logic [WIDTH-1:0] wr_b,
    input  logic [AW:0]      num_vec,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [AW-1:0]    vec_idx,
    output logic             vec_strobe,
    output logic             vec_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic [AW:0]   num_lat;

    logic          num_ok;
    logic          hold_last;
    logic          vec_last;
    logic          load;
    logic [AW-1:0] load_addr;
    logic [2*WIDTH-1:0] rd_data;

    assign num_ok    = (num_vec != '0) && (num_vec <= (AW+1)'(DEPTH));
    assign hold_last = (hold_cnt == CW'(HOLD_CYCLES - 1));
    assign vec_last  = ({1'b0, vec_idx} == (num_lat - (AW+1)'(1)));

    // The read register of the table is the a_out/b_out register; it only
    // captures on load edges, so the outputs hold through stop and DONE.
    always_comb begin
        load      = 1'b0;
        load_addr = '0;
        case (state)
            IDLE: load = start && !stop && num_ok;
            RUN: begin
                if (!stop && hold_last) begin
                    if (!vec_last) begin
                        load      = 1'b1;
                        load_addr = vec_idx + AW'(1);
                    end else begin
                        load = loop_en;
                    end
                end
            end
            default: ;
        endcase
    end

    ex_103_vector_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({wr_a, wr_b}),
        .rd_en   (load),
        .rd_addr (load_addr),
        .rd_data (rd_data)
    );

    assign a_out = rd_data[2*WIDTH-1:WIDTH];
    assign b_out = rd_data[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            num_lat    <= '0;
            vec_idx    <= '0;
            vec_strobe <= 1'b0;
            vec_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            vec_strobe <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (num_ok) begin
                            num_lat    <= num_vec;
                            vec_idx    <= '0;
                            hold_cnt   <= '0;
                            vec_strobe <= 1'b1;
                            vec_valid  <= 1'b1;
                            busy       <= 1'b1;
                            state      <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        vec_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (hold_last) begin
                        hold_cnt <= '0;
                        if (!vec_last) begin
                            vec_idx    <= load_addr;
                            vec_strobe <= 1'b1;
                        end else if (loop_en) begin
                            vec_idx    <= '0;
                            vec_strobe <= 1'b1;
                        end else begin
                            vec_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ex_103_vector_sequencer.md
Name: ex_103_vector_sequencer

Overview:
- Upstream stimulus stage for the AND test-vector block (ports a, b, out1, out2, out3).
- Holds a writable table of (a, b) operand pairs and presents them one after another on registered outputs, each held for a programmable number of clocks.
- Replaces hand-timed #delay stimulus with a synthesizable, cycle-exact sequencer.
- Supports start/stop control, optional looping and a completion pulse.

Parameters:
- WIDTH, 9, operand width of a_out/b_out; matches the 9-bit a/b ports downstream.
- DEPTH, 8, number of table entries (power of two, >= 2).
- HOLD_CYCLES, 50, clocks each vector is held (>= 1).
- AW, $clog2(DEPTH), table address width (derived, not overridden).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  table write strobe.
- wr_addr  input  AW  table write address.
- wr_a  input  WIDTH  operand a to store.
- wr_b  input  WIDTH  operand b to store.
- num_vec  input  AW+1  number of entries to play (valid 1..DEPTH); sampled at start.
- loop_en  input  1  1 = wrap to entry 0 after the last entry instead of finishing.
- start  input  1  begin playback (level sampled each clock).
- stop  input  1  abort playback.
- a_out  output  WIDTH  current operand a, registered.
- b_out  output  WIDTH  current operand b, registered.
- vec_idx  output  AW  index of the vector on a_out/b_out.
- vec_strobe  output  1  1-cycle pulse in the first cycle a new vector is presented.
- vec_valid  output  1  high while a_out/b_out carry a playback vector.
- busy  output  1  high in RUN.
- done  output  1  1-cycle pulse at normal completion.
- err  output  1  1-cycle pulse when start is rejected.

Behaviour:
- Reset (async, immediate): state IDLE; a_out, b_out, vec_idx, hold counter and latched count = 0; vec_strobe, vec_valid, busy, done, err = 0. Table contents are not reset.
- FSM states: IDLE, RUN, DONE.
- IDLE + start + !stop + 1 <= num_vec <= DEPTH:
  - latch num_vec;
  - at next edge: a_out/b_out = table[0], vec_idx = 0, vec_strobe = 1, vec_valid = 1, busy = 1, hold counter = 0, state RUN.
- IDLE + start with num_vec = 0 or num_vec > DEPTH: stay IDLE; err = 1 for one cycle.
- IDLE + start + stop: stop wins; stay IDLE, no err.
- RUN, per-vector timing:
  - counter increments each clock.
  - When counter = HOLD_CYCLES-1, next edge loads the next entry, resets the counter and pulses vec_strobe.
  - Vector k is therefore presented for exactly HOLD_CYCLES clocks, starting T0 + k*HOLD_CYCLES, where T0 is the first presentation cycle.
- RUN, last entry (idx = latched_num-1) expiring:
  - loop_en = 1: wrap to idx 0 and continue; done is not pulsed.
  - loop_en = 0: go to DONE; a_out/b_out keep the last vector; vec_valid = 0; busy = 0.
- DONE: done = 1 for exactly one cycle, then IDLE unconditionally.
- RUN + stop: next edge state IDLE; vec_valid = 0, busy = 0; a_out/b_out/vec_idx hold their values; no done.
- start while in RUN or DONE is ignored; so are later changes to num_vec during RUN.
- HOLD_CYCLES = 1: a new vector every clock; vec_strobe stays high continuously.
- num_vec = 1, loop_en = 1: entry 0 is reloaded every HOLD_CYCLES clocks, with a vec_strobe pulse each time.
- Writes are accepted in any state.
  - Outputs are sampled from the table only at load edges.
  - A write to the presented entry takes effect only when that entry is next loaded.
  - A write in the same cycle as a load of the same address returns the old data (read-before-write).
- Reset mid-RUN: all outputs return to reset values asynchronously; the table is retained.

Decomposition:
- ex_103_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH = 9 constant shared with the AND block and its bench.
- Sub-module ex_103_vector_ram: DEPTH x 2*WIDTH table with a synchronous write port and a synchronous read port (read-before-write), no reset.
- FSM, hold counter and output registers live in the top module.

Test Plan:
- Load {000/000, 0FF/000, 0FF/0F0, 0AA/0FF}, HOLD_CYCLES = 5, num_vec = 4, loop_en = 0, start pulse:
  - each pair is held 5 clocks, with a vec_strobe at the start of each;
  - done pulses once at T0+20; final a_out = 0AA, b_out = 0FF, vec_valid = 0.
- Same table with loop_en = 1: after idx 3 returns to idx 0 (a_out = 000) at T0+20; done never asserts; stop at T0+27 -> busy = 0 next cycle, a_out = 0FF held.
- num_vec = 0, start -> err pulses 1 cycle, busy stays 0; num_vec = 9 (DEPTH = 8) gives the same result.
- start and stop both high in IDLE -> no state change, no err; start asserted during RUN -> sequence timing unaffected.
- During RUN showing idx 1, write entry 1 = 1FF/1FF:
  - a_out stays 0FF until the loop revisits idx 1;
  - on that visit a_out = 1FF.
- Assert rst at T0+7 -> all outputs 0 immediately; after release, start again -> replays table from idx 0 with the stored contents intact.
